// File: rtl/pipe_hazard_seq_pkg.sv
// Shared types for the pipeline sequencing controller: FSM state encoding and the
// decoder opcode constants the surrounding core already uses.
package pipe_hazard_seq_pkg;

    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_ERR      = 2'd3
    } seq_state_e;

    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_SW  = 6'h2b;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_J   = 6'h02;

endpackage

// File: rtl/pipe_hazard_seq_if.sv
// Hazard/sequencing bundle between the ID-stage datapath (master) and the sequencer (slave).
// Pure wires, no latency; the memory side is a level req/ack handshake.
interface pipe_hazard_seq_if #(
    parameter int CNT_W = 16
);
    logic             start_i;
    logic [4:0]       IF_ID_Rs_i;
    logic [4:0]       IF_ID_Rt_i;
    logic [4:0]       ID_EX_Rt_i;
    logic             ID_EX_MemRead_i;
    logic             branch_taken_i;
    logic             jump_i;
    logic             mem_req_i;
    logic             mem_ack_i;
    logic             pc_write_o;
    logic             if_id_write_o;
    logic             if_id_flush_o;
    logic             id_ex_bubble_o;
    logic             pipe_hold_o;
    logic             mem_strobe_o;
    logic             err_o;
    logic [CNT_W-1:0] stall_cnt_o;

    modport master (
        output start_i, IF_ID_Rs_i, IF_ID_Rt_i, ID_EX_Rt_i, ID_EX_MemRead_i,
               branch_taken_i, jump_i, mem_req_i, mem_ack_i,
        input  pc_write_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o,
               pipe_hold_o, mem_strobe_o, err_o, stall_cnt_o
    );

    modport slave (
        input  start_i, IF_ID_Rs_i, IF_ID_Rt_i, ID_EX_Rt_i, ID_EX_MemRead_i,
               branch_taken_i, jump_i, mem_req_i, mem_ack_i,
        output pc_write_o, if_id_write_o, if_id_flush_o, id_ex_bubble_o,
               pipe_hold_o, mem_strobe_o, err_o, stall_cnt_o
    );
endinterface

// File: rtl/pipe_hazard_seq_hazard_detect.sv
// Load-use compare: a lw in EX whose destination feeds either source of the ID instruction.
// Purely combinational, no backpressure.
module hazard_detect
    import pipe_hazard_seq_pkg::*;
(
    input  logic             id_ex_memread_i,
    input  logic [REG_W-1:0] id_ex_rt_i,
    input  logic [REG_W-1:0] if_id_rs_i,
    input  logic [REG_W-1:0] if_id_rt_i,
    output logic             load_use_o
);
    // $zero is never a real dependency even when a lw targets it.
    assign load_use_o = id_ex_memread_i && (id_ex_rt_i != '0) &&
                        ((id_ex_rt_i == if_id_rs_i) || (id_ex_rt_i == if_id_rt_i));
endmodule

// File: rtl/pipe_hazard_seq.sv
// Pipeline sequencer: start-up hold, load-use stall, branch/jump flush, multi-cycle memory wait.
// Controls are combinational from state and inputs; a memory miss freezes the pipe until ack or timeout.
module pipe_hazard_seq
    import pipe_hazard_seq_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int TO_W        = 7,
    parameter int CNT_W       = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    pipe_hazard_seq_if.slave   bus
);
    seq_state_e       state_q, state_d;
    logic [TO_W-1:0]  wait_q;
    logic [CNT_W-1:0] stall_q;
    logic             err_q;
    logic             load_use;
    logic             mem_miss;

    logic pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold, mem_strobe;

    hazard_detect u_hazard_detect (
        .id_ex_memread_i (bus.ID_EX_MemRead_i),
        .id_ex_rt_i      (bus.ID_EX_Rt_i),
        .if_id_rs_i      (bus.IF_ID_Rs_i),
        .if_id_rt_i      (bus.IF_ID_Rt_i),
        .load_use_o      (load_use)
    );

    assign mem_miss = bus.mem_req_i && !bus.mem_ack_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (bus.start_i) state_d = ST_RUN;
            ST_RUN:      if (mem_miss) state_d = ST_MEM_WAIT;
            ST_MEM_WAIT: begin
                if (bus.mem_ack_i)                            state_d = ST_RUN;
                else if (wait_q == TO_W'(MEM_TIMEOUT - 1))    state_d = ST_ERR;
            end
            ST_ERR:      state_d = ST_ERR;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Default is a full freeze; only RUN and an acknowledged MEM_WAIT let the pipe move.
    always_comb begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        pipe_hold    = 1'b1;
        mem_strobe   = 1'b0;
        case (state_q)
            ST_RUN: begin
                mem_strobe = bus.mem_req_i;
                if (!mem_miss) begin
                    pipe_hold    = 1'b0;
                    pc_write     = !load_use;
                    if_id_write  = !load_use;
                    id_ex_bubble = load_use;
                    if_id_flush  = (bus.branch_taken_i || bus.jump_i) && !load_use;
                end
            end
            ST_MEM_WAIT: begin
                mem_strobe = 1'b1;
                if (bus.mem_ack_i) begin
                    pc_write    = 1'b1;
                    if_id_write = 1'b1;
                    pipe_hold   = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wait_q  <= '0;
            stall_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state_q == ST_MEM_WAIT && !bus.mem_ack_i) wait_q <= wait_q + 1'b1;
            else                                          wait_q <= '0;
            if ((state_q == ST_RUN || state_q == ST_MEM_WAIT) && !pc_write && stall_q != '1)
                stall_q <= stall_q + 1'b1;
            if (state_d == ST_ERR) err_q <= 1'b1;
        end
    end

    assign bus.pc_write_o     = pc_write;
    assign bus.if_id_write_o  = if_id_write;
    assign bus.if_id_flush_o  = if_id_flush;
    assign bus.id_ex_bubble_o = id_ex_bubble;
    assign bus.pipe_hold_o    = pipe_hold;
    assign bus.mem_strobe_o   = mem_strobe;
    assign bus.err_o          = err_q;
    assign bus.stall_cnt_o    = stall_q;

endmodule

// File: tb/tb_pipe_hazard_seq.sv
// Randomized and directed bench for pipe_hazard_seq against a cycle-level behavioural model.
// Inputs change just after the falling edge; outputs are compared 1ns later.
module tb_pipe_hazard_seq;
    localparam int MEM_TIMEOUT = 8;
    localparam int CNT_W       = 16;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    always #5 clk_i = ~clk_i;

    pipe_hazard_seq_if #(.CNT_W(CNT_W)) bus ();

    pipe_hazard_seq #(.MEM_TIMEOUT(MEM_TIMEOUT), .TO_W(7), .CNT_W(CNT_W)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: started / waiting-on-memory / errored flags plus plain counts.
    bit m_started, m_waiting, m_err;
    int m_wait_n, m_stall;
    bit e_pc, e_ifid, e_flush, e_bub, e_hold, e_strobe;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_started = 0; m_waiting = 0; m_err = 0; m_wait_n = 0; m_stall = 0;
    endtask

    task automatic model_outputs();
        bit lu;
        lu = bus.ID_EX_MemRead_i && (bus.ID_EX_Rt_i != 5'd0) &&
             (bus.ID_EX_Rt_i == bus.IF_ID_Rs_i || bus.ID_EX_Rt_i == bus.IF_ID_Rt_i);
        e_pc = 0; e_ifid = 0; e_flush = 0; e_bub = 0; e_hold = 1; e_strobe = 0;
        if (m_err || !m_started) begin
        end else if (m_waiting) begin
            e_strobe = 1;
            if (bus.mem_ack_i) begin e_pc = 1; e_ifid = 1; e_hold = 0; end
        end else if (bus.mem_req_i && !bus.mem_ack_i) begin
            e_strobe = 1;
        end else begin
            e_strobe = bus.mem_req_i;
            e_hold   = 0;
            e_pc     = !lu;
            e_ifid   = !lu;
            e_bub    = lu;
            e_flush  = (bus.branch_taken_i || bus.jump_i) && !lu;
        end
    endtask

    task automatic model_step();
        if (m_err) return;
        if (!m_started) begin
            m_started = bus.start_i;
            return;
        end
        if (!e_pc && m_stall < 65535) m_stall++;
        if (m_waiting) begin
            if (bus.mem_ack_i) m_waiting = 0;
            else begin
                m_wait_n++;
                if (m_wait_n == MEM_TIMEOUT) m_err = 1;
            end
        end else if (bus.mem_req_i && !bus.mem_ack_i) begin
            m_waiting = 1;
            m_wait_n  = 0;
        end
    endtask

    task automatic check_all(input string pfx);
        model_outputs();
        chk({pfx, ".pc_write"},  bus.pc_write_o,     e_pc);
        chk({pfx, ".if_id_wr"},  bus.if_id_write_o,  e_ifid);
        chk({pfx, ".flush"},     bus.if_id_flush_o,  e_flush);
        chk({pfx, ".bubble"},    bus.id_ex_bubble_o, e_bub);
        chk({pfx, ".hold"},      bus.pipe_hold_o,    e_hold);
        chk({pfx, ".strobe"},    bus.mem_strobe_o,   e_strobe);
        chk({pfx, ".err"},       bus.err_o,          m_err);
        chk({pfx, ".stall_cnt"}, bus.stall_cnt_o,    m_stall);
    endtask

    task automatic cycle(input string pfx);
        #1;
        check_all(pfx);
        @(posedge clk_i);
        model_step();
        @(negedge clk_i);
    endtask

    task automatic clear_inputs();
        bus.start_i = 0; bus.IF_ID_Rs_i = 0; bus.IF_ID_Rt_i = 0; bus.ID_EX_Rt_i = 0;
        bus.ID_EX_MemRead_i = 0; bus.branch_taken_i = 0; bus.jump_i = 0;
        bus.mem_req_i = 0; bus.mem_ack_i = 0;
    endtask

    task automatic do_reset(input string pfx);
        rst_i = 0;
        #1;
        model_reset();
        check_all(pfx);
        @(negedge clk_i);
        rst_i = 1;
    endtask

    task automatic start_up();
        clear_inputs();
        bus.start_i = 1;
        cycle("start");
        bus.start_i = 0;
    endtask

    int s0, n_strobe, n_hold;

    initial begin
        clear_inputs();
        do_reset("reset");

        // Idle holds regardless of other inputs.
        bus.mem_req_i = 1; bus.branch_taken_i = 1;
        repeat (3) cycle("idle");
        start_up();
        #1 chk("first_fetch", bus.pc_write_o, 1);
        cycle("run");

        // Load-use on rs=2, then the bubble removes the lw from EX.
        s0 = m_stall;
        bus.ID_EX_MemRead_i = 1; bus.ID_EX_Rt_i = 2; bus.IF_ID_Rs_i = 2; bus.IF_ID_Rt_i = 7;
        #1 chk("lu_bubble", bus.id_ex_bubble_o, 1);
        cycle("lu");
        chk("lu_stall_cnt", bus.stall_cnt_o, s0 + 1);
        bus.ID_EX_MemRead_i = 0;
        cycle("lu_after");

        // lw targeting $zero is not a hazard.
        bus.ID_EX_MemRead_i = 1; bus.ID_EX_Rt_i = 0; bus.IF_ID_Rs_i = 0;
        #1 chk("rt0_pc_write", bus.pc_write_o, 1);
        cycle("rt0");

        // Load-use and taken branch together: bubble first, flush next cycle.
        bus.ID_EX_MemRead_i = 1; bus.ID_EX_Rt_i = 5; bus.IF_ID_Rt_i = 5; bus.branch_taken_i = 1;
        #1 chk("lu_br_c1_flush", bus.if_id_flush_o, 0);
        cycle("lu_br1");
        bus.ID_EX_MemRead_i = 0;
        #1 chk("lu_br_c2_flush", bus.if_id_flush_o, 1);
        chk("lu_br_c2_bubble", bus.id_ex_bubble_o, 0);
        cycle("lu_br2");
        clear_inputs();

        // Memory access acknowledged on the fourth strobe cycle.
        s0 = m_stall; n_strobe = 0; n_hold = 0;
        bus.mem_req_i = 1;
        for (int i = 0; i < 4; i++) begin
            bus.mem_ack_i = (i == 3);
            #1;
            n_strobe += bus.mem_strobe_o;
            n_hold   += bus.pipe_hold_o;
            if (i == 3) chk("ack_release", bus.pc_write_o, 1);
            cycle("mem");
        end
        clear_inputs();
        chk("mem_strobe_cycles", n_strobe, 4);
        chk("mem_hold_cycles", n_hold, 3);
        chk("mem_stall_delta", bus.stall_cnt_o, s0 + 3);
        cycle("post_mem");

        // Timeout: no ack ever; ERR after MEM_TIMEOUT wait cycles, sticky, start ignored.
        bus.mem_req_i = 1;
        repeat (1 + MEM_TIMEOUT) cycle("to");
        chk("err_set", bus.err_o, 1);
        bus.start_i = 1;
        repeat (3) cycle("err_hold");
        chk("err_sticky", bus.err_o, 1);
        rst_i = 0;
        #1 chk("err_async_clear", bus.err_o, 0);
        clear_inputs();
        do_reset("reset2");

        // Reset in the middle of a memory wait.
        start_up();
        bus.mem_req_i = 1;
        repeat (3) cycle("pre_rst");
        chk("wait_strobe", bus.mem_strobe_o, 1);
        do_reset("mid_wait_rst");
        chk("mid_wait_strobe", bus.mem_strobe_o, 0);
        clear_inputs();

        // Randomized segments, each from a fresh reset.
        for (int seg = 0; seg < 6; seg++) begin
            do_reset("rnd_rst");
            start_up();
            for (int i = 0; i < 300; i++) begin
                bus.start_i         = ($urandom_range(0, 9) == 0);
                bus.IF_ID_Rs_i      = 5'($urandom_range(0, 3));
                bus.IF_ID_Rt_i      = 5'($urandom_range(0, 3));
                bus.ID_EX_Rt_i      = 5'($urandom_range(0, 3));
                bus.ID_EX_MemRead_i = ($urandom_range(0, 2) == 0);
                bus.branch_taken_i  = ($urandom_range(0, 4) == 0);
                bus.jump_i          = ($urandom_range(0, 7) == 0);
                bus.mem_req_i       = m_waiting ? 1'b1 : ($urandom_range(0, 4) == 0);
                bus.mem_ack_i       = ($urandom_range(0, 2) == 0);
                cycle("rnd");
            end
            clear_inputs();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/pipe_hazard_seq.md
Name: pipe_hazard_seq

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core.
- Sits beside the ID-stage decoder and drives the PC, IF/ID, ID/EX and whole-pipe hold controls.
- Handles start-up, load-use stalls, and branch/jump flushes of IF/ID.
- Runs the multi-cycle data-memory request/acknowledge handshake, with a timeout error and a stall-cycle counter.

Parameters:
- MEM_TIMEOUT, 64: max cycles spent in MEM_WAIT before entering ERR.
- TO_W, 7: width of the wait counter; must hold MEM_TIMEOUT.
- CNT_W, 16: width of the stall-cycle counter.

Ports:
- clk_i, input, 1: core clock.
- rst_i, input, 1: reset, asynchronous, active-low.
- start_i, input, 1: leaves IDLE and begins fetching.
- IF_ID_Rs_i, input, 5: rs of the instruction in ID.
- IF_ID_Rt_i, input, 5: rt of the instruction in ID.
- ID_EX_Rt_i, input, 5: rt of the instruction in EX.
- ID_EX_MemRead_i, input, 1: EX instruction is lw.
- branch_taken_i, input, 1: beq in ID resolved taken.
- jump_i, input, 1: j in ID.
- mem_req_i, input, 1: MEM stage holds lw/sw.
- mem_ack_i, input, 1: data memory completes the access.
- pc_write_o, output, 1: PC load enable.
- if_id_write_o, output, 1: IF/ID load enable.
- if_id_flush_o, output, 1: zero IF/ID.
- id_ex_bubble_o, output, 1: force ID/EX control bits to 0.
- pipe_hold_o, output, 1: freeze ID/EX, EX/MEM and MEM/WB.
- mem_strobe_o, output, 1: request to data memory.
- err_o, output, 1: memory timeout; sticky.
- stall_cnt_o, output, CNT_W: count of stalled cycles.

Behaviour:
- Reset (rst_i=0, async) forces:
  - state=IDLE, wait counter=0, stall_cnt_o=0, err_o=0.
  - pc_write_o=0, if_id_write_o=0, pipe_hold_o=1, if_id_flush_o=0, id_ex_bubble_o=0, mem_strobe_o=0.
- States: IDLE, RUN, MEM_WAIT, ERR.
- Outputs are combinational from state and inputs; state, counters and err_o are registered.
- IDLE:
  - Holds pipe (pc_write_o=0, if_id_write_o=0, pipe_hold_o=1); all other inputs ignored.
  - start_i=1 -> RUN next edge. First fetch occurs in the first RUN cycle.
- RUN, default: pc_write_o=1, if_id_write_o=1, pipe_hold_o=0.
- RUN, load-use hazard:
  - Condition: ID_EX_MemRead_i=1 and ID_EX_Rt_i!=0 and (ID_EX_Rt_i==IF_ID_Rs_i or ID_EX_Rt_i==IF_ID_Rt_i).
  - Response: pc_write_o=0, if_id_write_o=0, id_ex_bubble_o=1. Exactly one stall cycle per occurrence.
- RUN, control flush:
  - branch_taken_i or jump_i, with no load-use hazard -> if_id_flush_o=1 for that cycle.
  - A load-use hazard suppresses the flush; the flush is taken on the next cycle when re-evaluated.
- RUN, memory access:
  - mem_req_i=1 -> mem_strobe_o=1.
  - mem_ack_i=1 in the same cycle: zero-wait access, stay in RUN.
  - Otherwise -> MEM_WAIT next edge. The current cycle already holds: pc_write_o=0, if_id_write_o=0, pipe_hold_o=1; flush and bubble are suppressed.
- MEM_WAIT:
  - mem_strobe_o=1, full freeze; wait counter increments each cycle.
  - mem_ack_i=1: hold released in that same cycle (pc_write_o=1, pipe_hold_o=0); -> RUN; wait counter cleared.
  - Hazard, flush and bubble are evaluated only in RUN. In MEM_WAIT they are masked, including on the ack cycle.
  - Wait counter reaching MEM_TIMEOUT-1 with no ack -> ERR.
- ERR:
  - Full freeze, mem_strobe_o=0, err_o=1.
  - Left only by reset; start_i ignored.
- stall_cnt_o:
  - +1 on each cycle in RUN or MEM_WAIT with pc_write_o=0.
  - Saturates at all-ones.
- Reset mid-MEM_WAIT: strobe drops immediately (async); memory must tolerate request withdrawal.

Decomposition:
- Shared package holds:
  - State encoding: IDLE=2'd0, RUN=2'd1, MEM_WAIT=2'd2, ERR=2'd3.
  - The lw/sw/beq/j opcode constants already used by the decoder.
- One sub-module: hazard_detect, a pure combinational load-use compare, reused by the forwarding unit's tests.
- FSM and counters stay in the top module.

Test Plan:
- Reset then start_i pulse:
  - pc_write_o=0 and pipe_hold_o=1 through IDLE.
  - pc_write_o=1 from the cycle after start_i.
- lw $2 in EX, ID reads rs=2:
  - One cycle of pc_write_o=0, if_id_write_o=0, id_ex_bubble_o=1; stall_cnt_o=1.
  - Same case with rt=0 in EX: no stall.
- Load-use and branch_taken_i in the same cycle:
  - Cycle 1: bubble=1, flush=0.
  - Cycle 2 (branch_taken_i still 1): flush=1, bubble=0.
- mem_req_i with mem_ack_i asserted after 3 cycles:
  - mem_strobe_o high for 4 cycles, pipe_hold_o high for 3.
  - Release on the ack cycle; stall_cnt_o +=3.
- mem_req_i with mem_ack_i never asserted, MEM_TIMEOUT=8:
  - ERR entered; err_o=1 and held; start_i has no effect.
  - rst_i low clears err_o immediately.
- rst_i asserted mid-MEM_WAIT:
  - mem_strobe_o=0 and state=IDLE without a clock edge.
